uram_read_stage: RTL and testbench
==================================

Name: uram_read_stage

Overview:
- Request/response front-end that drives one simple dual-port URAM macro: one write port (always accepted), one read port with 1-cycle read latency and read-first collision semantics.
- Accepts tagged read requests over a valid/ready handshake and issues them to the macro's raddr.
- Captures the macro's dout on the cycle after issue into a small response FIFO, and returns tagged responses downstream under backpressure.
- Sits directly upstream of the URAM instance, in the same clock domain; the macro's outputs feed back into this block.

Parameters:
- DATA_WIDTH, 64, word width; matches the memory macro.
- ADDRESS_WIDTH, 12, word address width; matches the memory macro.
- TAG_WIDTH, 4, opaque request tag returned unchanged with each response.
- FIFO_DEPTH, 3, response FIFO entries; legal range 2..8. Depth ≥3 gives 1 read/cycle sustained; depth 2 inserts bubbles.

Ports:
- clock  in  1  Single clock for the whole block and the memory macro.
- reset_n  in  1  Asynchronous, active-low reset.
- req_valid  in  1  Read request valid.
- req_ready  out  1  Read request accepted when req_valid && req_ready.
- req_addr  in  ADDRESS_WIDTH  Read word address.
- req_tag  in  TAG_WIDTH  Tag returned with the response.
- wr_valid  in  1  Write strobe; always accepted.
- wr_addr  in  ADDRESS_WIDTH  Write word address.
- wr_data  in  DATA_WIDTH  Write data.
- resp_valid  out  1  Response valid.
- resp_ready  in  1  Downstream accepts the response.
- resp_data  out  DATA_WIDTH  Read data.
- resp_tag  out  TAG_WIDTH  Tag of the returned request.
- mem_raddr  out  ADDRESS_WIDTH  To macro raddr; driven combinationally from req_addr.
- mem_dout  in  DATA_WIDTH  From macro dout; valid 1 cycle after raddr is sampled.
- mem_wen  out  1  To macro wen; equals wr_valid.
- mem_waddr  out  ADDRESS_WIDTH  To macro waddr; equals wr_addr.
- mem_din  out  DATA_WIDTH  To macro din; equals wr_data.

Behaviour:
- Reset (reset_n low, asynchronous): in-flight flag, tag and bypass registers cleared; FIFO emptied, pointers 0. Outputs: resp_valid=0, resp_data=0, resp_tag=0, req_ready=0 while reset is asserted; req_ready=1 from the first cycle after deassertion.
- Reset mid-operation: any in-flight read is dropped, and its mem_dout on the following cycle is ignored. Buffered responses are lost.
- Credit rule: occupancy = FIFO count + in-flight flag (0/1).
  - req_ready = (occupancy < FIFO_DEPTH), computed from registered state only; no combinational path from resp_ready.
  - Requests are never dropped.
- Issue cycle T (req fire):
  - in-flight set; req_tag registered.
  - At the T+1 edge, mem_dout (or the bypass value) and the tag are pushed into the FIFO.
- Latency: resp_valid is asserted no earlier than cycle T+2 for a request firing in cycle T.
- Ordering: responses are returned strictly in request order.
- FIFO:
  - resp_* driven from the FIFO head; head is popped on resp_valid && resp_ready.
  - Push and pop in the same cycle are allowed at any count, including full.
  - Read/write pointers wrap modulo FIFO_DEPTH.
  - FIFO overflow cannot occur by construction. Overflow is a verification assertion.
- Throughput: with resp_ready held at 1 and FIFO_DEPTH ≥ 3, one request is accepted per cycle indefinitely.
- Write path: fully combinational pass-through, independent of read state, and unaffected by backpressure.
- Collision (req fire and wr_valid in the same cycle with req_addr == wr_addr): behaviour is set by the Optional Feature.
- Collision (write to an address one cycle after its read issued): no effect; the returned data is the pre-write value.

Optional Feature:
- Macro: URAM_READ_STAGE_BYPASS_EN.
- Defined:
  - On a same-cycle collision, wr_data and a bypass flag are registered; at T+1 the FIFO pushes the registered wr_data instead of mem_dout (write-first semantics).
  - Addresses are compared at full ADDRESS_WIDTH.
- Undefined:
  - No comparator and no bypass registers.
  - A collision returns the old memory contents (read-first semantics of the macro).

Test Plan:
- Reset, then idle → resp_valid=0, req_ready=1 on the first cycle after reset_n rises; with no requests, no response ever appears.
- Write addr 0x010 = 0xDEAD_BEEF; 2 cycles later, read 0x010 with tag 5 → resp_valid at T+2 with data 0xDEADBEEF and tag 5.
- Back-to-back reads 0x000..0x00F (memory preloaded with mem[i]=i) with resp_ready=1 and FIFO_DEPTH=3 → 16 responses on consecutive cycles, data 0..15 in order, req_ready never drops.
- Same stream with resp_ready held low → req_ready falls once occupancy = 3. Releasing resp_ready then drains data 0,1,2 in order, and issue resumes without loss or duplication.
- Preload mem[0x020]=0x1111; in the same cycle, write 0x2222 to 0x020 and read 0x020 → response 0x2222 with the macro defined, 0x1111 without it.
- With 2 responses buffered and 1 read in flight, pulse reset_n low for 1 cycle → resp_valid=0 immediately; no stale response appears afterwards; the next read returns correct data.

Source files
------------

// File: rtl/uram_read_stage.sv
// uram_read_stage: tagged read front-end for a 1-cycle-latency read-first URAM, with response FIFO and credit-based req_ready.
// Define URAM_READ_STAGE_BYPASS_EN for write-first forwarding on same-cycle read/write address collisions.
module uram_read_stage #(
    parameter int DATA_WIDTH    = 64,
    parameter int ADDRESS_WIDTH = 12,
    parameter int TAG_WIDTH     = 4,
    parameter int FIFO_DEPTH    = 3
) (
    input  logic                     clock,
    input  logic                     reset_n,
    input  logic                     req_valid,
    output logic                     req_ready,
    input  logic [ADDRESS_WIDTH-1:0] req_addr,
    input  logic [TAG_WIDTH-1:0]     req_tag,
    input  logic                     wr_valid,
    input  logic [ADDRESS_WIDTH-1:0] wr_addr,
    input  logic [DATA_WIDTH-1:0]    wr_data,
    output logic                     resp_valid,
    input  logic                     resp_ready,
    output logic [DATA_WIDTH-1:0]    resp_data,
    output logic [TAG_WIDTH-1:0]     resp_tag,
    output logic [ADDRESS_WIDTH-1:0] mem_raddr,
    input  logic [DATA_WIDTH-1:0]    mem_dout,
    output logic                     mem_wen,
    output logic [ADDRESS_WIDTH-1:0] mem_waddr,
    output logic [DATA_WIDTH-1:0]    mem_din
);
    localparam int PW = $clog2(FIFO_DEPTH);
    localparam int CW = $clog2(FIFO_DEPTH + 1);

    logic                  in_flight;
    logic [TAG_WIDTH-1:0]  tag_q;
    logic [DATA_WIDTH-1:0] fifo_data [FIFO_DEPTH];
    logic [TAG_WIDTH-1:0]  fifo_tag  [FIFO_DEPTH];
    logic [PW-1:0]         wr_ptr, rd_ptr;
    logic [CW-1:0]         count;
    logic [CW:0]           occupancy;
    logic                  req_fire, push, pop;
    logic [DATA_WIDTH-1:0] push_data;

    function automatic logic [PW-1:0] next_ptr(input logic [PW-1:0] p);
        return (p == PW'(FIFO_DEPTH - 1)) ? '0 : p + 1'b1;
    endfunction

    assign mem_raddr = req_addr;
    assign mem_wen   = wr_valid;
    assign mem_waddr = wr_addr;
    assign mem_din   = wr_data;

    // The in-flight read holds a credit so its response always has a FIFO slot.
    assign occupancy  = {1'b0, count} + (CW + 1)'(in_flight);
    assign req_ready  = reset_n && (occupancy < (CW + 1)'(FIFO_DEPTH));
    assign req_fire   = req_valid && req_ready;
    assign push       = in_flight;
    assign resp_valid = (count != '0);
    assign pop        = resp_valid && resp_ready;
    assign resp_data  = resp_valid ? fifo_data[rd_ptr] : '0;
    assign resp_tag   = resp_valid ? fifo_tag[rd_ptr] : '0;

`ifdef URAM_READ_STAGE_BYPASS_EN
    logic                  bypass_q;
    logic [DATA_WIDTH-1:0] bypass_data_q;

    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            bypass_q      <= 1'b0;
            bypass_data_q <= '0;
        end else begin
            bypass_q <= req_fire && wr_valid && (req_addr == wr_addr);
            if (req_fire && wr_valid)
                bypass_data_q <= wr_data;
        end
    end

    assign push_data = bypass_q ? bypass_data_q : mem_dout;
`else
    assign push_data = mem_dout;
`endif

    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            in_flight <= 1'b0;
            tag_q     <= '0;
            wr_ptr    <= '0;
            rd_ptr    <= '0;
            count     <= '0;
        end else begin
            assert (!(push && !pop && count == CW'(FIFO_DEPTH)));
            in_flight <= req_fire;
            if (req_fire)
                tag_q <= req_tag;
            if (push)
                wr_ptr <= next_ptr(wr_ptr);
            if (pop)
                rd_ptr <= next_ptr(rd_ptr);
            count <= count + CW'(push) - CW'(pop);
        end
    end

    always_ff @(posedge clock) begin
        if (push) begin
            fifo_data[wr_ptr] <= push_data;
            fifo_tag[wr_ptr]  <= tag_q;
        end
    end
endmodule

// File: tb/tb_uram_read_stage.sv
// tb_uram_read_stage: randomized + directed bench with a URAM macro model and a queue-based response scoreboard.
// Build with URAM_READ_STAGE_BYPASS_EN to expect write-first collision data.
module tb_uram_read_stage;
    localparam int DW = 64, AW = 12, TW = 4, DEPTH = 3;
`ifdef URAM_READ_STAGE_BYPASS_EN
    localparam bit BYP = 1'b1;
`else
    localparam bit BYP = 1'b0;
`endif

    logic          clock = 1'b0, reset_n = 1'b0;
    logic          req_valid = 1'b0, req_ready;
    logic [AW-1:0] req_addr = '0;
    logic [TW-1:0] req_tag = '0;
    logic          wr_valid = 1'b0;
    logic [AW-1:0] wr_addr = '0;
    logic [DW-1:0] wr_data = '0;
    logic          resp_valid, resp_ready = 1'b0;
    logic [DW-1:0] resp_data;
    logic [TW-1:0] resp_tag;
    logic [AW-1:0] mem_raddr, mem_waddr;
    logic [DW-1:0] mem_dout, mem_din;
    logic          mem_wen;

    uram_read_stage #(.DATA_WIDTH(DW), .ADDRESS_WIDTH(AW), .TAG_WIDTH(TW), .FIFO_DEPTH(DEPTH)) dut (
        .clock(clock), .reset_n(reset_n),
        .req_valid(req_valid), .req_ready(req_ready), .req_addr(req_addr), .req_tag(req_tag),
        .wr_valid(wr_valid), .wr_addr(wr_addr), .wr_data(wr_data),
        .resp_valid(resp_valid), .resp_ready(resp_ready), .resp_data(resp_data), .resp_tag(resp_tag),
        .mem_raddr(mem_raddr), .mem_dout(mem_dout), .mem_wen(mem_wen), .mem_waddr(mem_waddr), .mem_din(mem_din)
    );

    always #5 clock = ~clock;

    // Simple dual-port macro, read-first, one-cycle read latency.
    logic [DW-1:0] umem [0:(1<<AW)-1];
    always @(posedge clock) begin
        mem_dout <= umem[mem_raddr];
        if (mem_wen) umem[mem_waddr] <= mem_din;
    end

    int n_checks = 0, n_pass = 0, cyc = 0;
    always @(posedge clock) cyc++;

    task automatic chk(input string name, input logic [DW-1:0] got, input logic [DW-1:0] exp);
        n_checks++;
        if (got === exp) n_pass++;
        else $display("FAIL %s: got %0h expected %0h (cycle %0d)", name, got, exp, cyc);
    endtask

    typedef struct { logic [DW-1:0] d; logic [TW-1:0] t; int c; } ent_t;
    ent_t          q[$];
    logic [DW-1:0] ref_mem [0:(1<<AW)-1];
    logic [DW-1:0] seen[$];
    int            seen_c[$];

    // Model: every accepted request owes exactly one response, in order, no earlier than two cycles later.
    always @(negedge clock) begin
        ent_t e;
        bit exp_v;
        if (!reset_n) begin
            q.delete();
            chk("rst_resp_valid", resp_valid, 0);
            chk("rst_req_ready", req_ready, 0);
            chk("rst_resp_data", resp_data, 0);
            chk("rst_resp_tag", resp_tag, 0);
        end else begin
            exp_v = q.size() > 0 && q[0].c <= cyc - 2;
            chk("resp_valid", resp_valid, exp_v);
            chk("req_ready", req_ready, q.size() < DEPTH);
            if (exp_v && resp_valid) begin
                chk("resp_data", resp_data, q[0].d);
                chk("resp_tag", resp_tag, q[0].t);
                if (resp_ready) begin
                    seen.push_back(resp_data);
                    seen_c.push_back(cyc);
                    void'(q.pop_front());
                end
            end
            if (req_valid && req_ready) begin
                e.d = (BYP && wr_valid && wr_addr == req_addr) ? wr_data : ref_mem[req_addr];
                e.t = req_tag;
                e.c = cyc;
                q.push_back(e);
            end
        end
        if (wr_valid) ref_mem[wr_addr] = wr_data;
    end

    task automatic step();
        @(posedge clock);
        #1;
    endtask

    initial begin
        int nxt, budget;
        // Preload mem[i]=i through the write port while reset is held.
        for (int i = 0; i < 48; i++) begin
            wr_valid = 1'b1; wr_addr = AW'(i); wr_data = DW'(i);
            step();
        end
        wr_valid = 1'b0;
        reset_n = 1'b1;
        #1;
        chk("post_rst_ready", req_ready, 1);
        chk("post_rst_valid", resp_valid, 0);
        resp_ready = 1'b1;
        repeat (5) step();
        chk("idle_no_resp", resp_valid, 0);

        // Write then read with tag 5.
        wr_valid = 1'b1; wr_addr = 12'h010; wr_data = 64'hDEADBEEF;
        step();
        wr_valid = 1'b0;
        step(); step();
        req_valid = 1'b1; req_addr = 12'h010; req_tag = 4'd5;
        step();
        req_valid = 1'b0;
        chk("lat_t1_valid", resp_valid, 0);
        step();
        chk("lat_t2_valid", resp_valid, 1);
        chk("lat_t2_data", resp_data, 64'hDEADBEEF);
        chk("lat_t2_tag", resp_tag, 5);
        step(); step();

        // Back-to-back stream at full rate.
        seen.delete(); seen_c.delete();
        for (int i = 0; i < 16; i++) begin
            req_valid = 1'b1; req_addr = AW'(i); req_tag = TW'(i);
            chk("tput_ready", req_ready, 1);
            step();
        end
        req_valid = 1'b0;
        repeat (4) step();
        chk("tput_count", seen.size(), 16);
        for (int i = 0; i < 16 && i < seen.size(); i++) chk("tput_data", seen[i], DW'(i));
        if (seen.size() == 16) chk("tput_consecutive", seen_c[15] - seen_c[0], 15);

        // Backpressure: stall, then drain.
        seen.delete();
        resp_ready = 1'b0;
        nxt = 0;
        for (int k = 0; k < 6; k++) begin
            req_valid = 1'b1; req_addr = AW'(nxt); req_tag = TW'(nxt);
            if (req_ready) nxt++;
            step();
        end
        chk("bp_accepted", nxt, 3);
        chk("bp_ready_low", req_ready, 0);
        resp_ready = 1'b1;
        budget = 100;
        while (nxt < 16 && budget > 0) begin
            req_valid = 1'b1; req_addr = AW'(nxt); req_tag = TW'(nxt);
            if (req_ready) nxt++;
            step();
            budget--;
        end
        chk("bp_budget", nxt, 16);
        req_valid = 1'b0;
        repeat (5) step();
        chk("bp_count", seen.size(), 16);
        for (int i = 0; i < 16 && i < seen.size(); i++) chk("bp_data", seen[i], DW'(i));

        // Same-cycle collision.
        wr_valid = 1'b1; wr_addr = 12'h020; wr_data = 64'h1111;
        step();
        wr_valid = 1'b0;
        step();
        wr_valid = 1'b1; wr_data = 64'h2222;
        req_valid = 1'b1; req_addr = 12'h020; req_tag = 4'd7;
        step();
        wr_valid = 1'b0; req_valid = 1'b0;
        step();
        chk("coll_valid", resp_valid, 1);
        chk("coll_data", resp_data, BYP ? 64'h2222 : 64'h1111);
        step(); step();

        // Reset with two buffered and one in flight.
        resp_ready = 1'b0;
        for (int i = 4; i < 7; i++) begin
            req_valid = 1'b1; req_addr = AW'(i); req_tag = TW'(i);
            step();
        end
        req_valid = 1'b0;
        chk("pre_rst_valid", resp_valid, 1);
        reset_n = 1'b0;
        #1;
        chk("mid_rst_valid", resp_valid, 0);
        chk("mid_rst_ready", req_ready, 0);
        @(posedge clock);
        #1;
        reset_n = 1'b1;
        resp_ready = 1'b1;
        seen.delete();
        repeat (4) step();
        chk("no_stale", seen.size(), 0);
        req_valid = 1'b1; req_addr = 12'h009; req_tag = 4'd3;
        step();
        req_valid = 1'b0;
        step();
        chk("after_rst_valid", resp_valid, 1);
        chk("after_rst_data", resp_data, 64'h9);
        chk("after_rst_tag", resp_tag, 3);
        step();

        // Randomized traffic with frequent collisions and backpressure.
        for (int k = 0; k < 3000; k++) begin
            req_valid  = 1'($urandom_range(0, 1));
            req_addr   = AW'($urandom_range(32, 47));
            req_tag    = TW'($urandom);
            wr_valid   = 1'($urandom_range(0, 1));
            wr_addr    = AW'($urandom_range(32, 47));
            wr_data    = {$urandom, $urandom};
            resp_ready = ($urandom_range(0, 3) != 0);
            step();
        end
        req_valid = 1'b0; wr_valid = 1'b0; resp_ready = 1'b1;
        repeat (10) step();
        chk("drain_empty", resp_valid, 0);
        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end
endmodule
